// File: rtl/hps_spi_master_pkg.sv
// rtl/hps_spi_master_pkg.sv - FSM states, default word/timing parameters and sizing helper for the HPS SPI master.
package hps_spi_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LO,
      ST_HI,
      ST_NEXT,
      ST_HOLD,
      ST_GAP
   } spi_state_t;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_CLK_DIV  = 4;
   localparam int DEF_CS_SETUP = 2;
   localparam int DEF_CS_HOLD  = 8;
   localparam int DEF_CS_GAP   = 4;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/hps_spi_master_sck_gen.sv
// rtl/hps_spi_master_sck_gen.sv - SCK half-period timer; restarts whenever the bit phase is not running.
module hps_spi_master_sck_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_run,
   output logic o_tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] r_cnt;

   // o_tick marks the last sys_clk cycle of the current SCK half-period.
   assign o_tick = i_run && (r_cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (!i_run || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/hps_spi_master.sv
// rtl/hps_spi_master.sv - SPI master for the HPS command link: CS framing, MSB-first 16-bit words, mode-0 timing.
module hps_spi_master
   import hps_spi_master_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int CS_SETUP = DEF_CS_SETUP,
   parameter int CS_HOLD  = DEF_CS_HOLD,
   parameter int CS_GAP   = DEF_CS_GAP
) (
   input  logic             i_sys_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_tx_data,
   input  logic             i_tx_last,
   input  logic             i_tx_valid,
   output logic             o_tx_ready,
   output logic [WIDTH-1:0] o_rx_data,
   output logic             o_rx_valid,
   output logic             o_busy,
   output logic             o_spi_clk,
   output logic             o_spi_mosi,
   input  logic             i_spi_miso,
   output logic             o_spi_cs
);

   localparam int CNT_MAX = max_of(max_of(max_of(CLK_DIV, CS_SETUP), max_of(CS_HOLD, CS_GAP)), WIDTH);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   spi_state_t       r_state;
   spi_state_t       w_next_state;
   logic [WIDTH-1:0] r_tx_shift;
   logic [WIDTH-1:0] r_rx_shift;
   logic [WIDTH-1:0] r_rx_data;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_bit_cnt;
   logic             r_last;
   logic             r_tx_ready;
   logic             r_rx_valid;
   logic             r_busy;
   logic             r_sck;
   logic             r_mosi;
   logic             r_cs;
   logic             w_accept;
   logic             w_tick;
   logic             w_cnt_done;
   logic             w_last_bit;
   logic             w_run;

   assign w_accept   = i_tx_valid && r_tx_ready;
   assign w_run      = (r_state == ST_LO) || (r_state == ST_HI);
   assign w_last_bit = (r_bit_cnt == CNT_W'(WIDTH - 1));

   hps_spi_master_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .i_clk  (i_sys_clk),
      .i_rst  (i_reset),
      .i_run  (w_run),
      .o_tick (w_tick)
   );

   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_cnt_done   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next_state = ST_SETUP;
         end
         ST_SETUP: begin
            w_cnt_done = (r_cnt == CNT_W'(CS_SETUP - 1));
            if (w_cnt_done) w_next_state = ST_LO;
         end
         ST_LO: begin
            if (w_tick) w_next_state = ST_HI;
         end
         ST_HI: begin
            if (w_tick) begin
               if (!w_last_bit) w_next_state = ST_LO;
               else if (r_last)  w_next_state = ST_HOLD;
               else              w_next_state = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (w_accept) w_next_state = ST_LO;
         end
         ST_HOLD: begin
            w_cnt_done = (r_cnt == CNT_W'(CS_HOLD - 1));
            if (w_cnt_done) w_next_state = ST_GAP;
         end
         ST_GAP: begin
            w_cnt_done = (r_cnt == CNT_W'(CS_GAP - 1));
            if (w_cnt_done) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Ready/busy are registered from the next state so both are low while reset is held.
   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) begin
         r_tx_shift <= '0;
         r_rx_shift <= '0;
         r_rx_data  <= '0;
         r_cnt      <= '0;
         r_bit_cnt  <= '0;
         r_last     <= 1'b0;
         r_tx_ready <= 1'b0;
         r_rx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_sck      <= 1'b0;
         r_mosi     <= 1'b0;
         r_cs       <= 1'b1;
      end else begin
         r_tx_ready <= (w_next_state == ST_IDLE) || (w_next_state == ST_NEXT);
         r_busy     <= (w_next_state != ST_IDLE);
         r_rx_valid <= 1'b0;

         if (w_next_state != r_state) begin
            r_cnt <= '0;
         end else if ((r_state == ST_SETUP) || (r_state == ST_HOLD) || (r_state == ST_GAP)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if (w_accept) begin
            r_tx_shift <= i_tx_data;
            r_last     <= i_tx_last;
            r_mosi     <= i_tx_data[WIDTH-1];
            r_bit_cnt  <= '0;
         end
         if ((r_state == ST_IDLE) && w_accept) r_cs <= 1'b0;
         if ((r_state == ST_LO) && w_tick) r_sck <= 1'b1;

         // MISO is taken on the final HI cycle; MOSI advances on the same edge SCK falls.
         if ((r_state == ST_HI) && w_tick) begin
            r_sck      <= 1'b0;
            r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
            r_mosi     <= r_tx_shift[WIDTH-2];
            r_rx_shift <= {r_rx_shift[WIDTH-2:0], i_spi_miso};
            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
            if (w_last_bit) begin
               r_rx_data  <= {r_rx_shift[WIDTH-2:0], i_spi_miso};
               r_rx_valid <= 1'b1;
            end
         end
         if ((r_state == ST_HOLD) && w_cnt_done) r_cs <= 1'b1;
      end
   end

   assign o_tx_ready = r_tx_ready;
   assign o_rx_data  = r_rx_data;
   assign o_rx_valid = r_rx_valid;
   assign o_busy     = r_busy;
   assign o_spi_clk  = r_sck;
   assign o_spi_mosi = r_mosi;
   assign o_spi_cs   = r_cs;

endmodule

// File: tb/tb_hps_spi_master.sv
// tb/tb_hps_spi_master.sv - directed bench for hps_spi_master with behavioural SPI slaves.
module tb_hps_spi_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [15:0] tx_data = '0;
   logic        tx_last = 1'b0;
   logic        tx_valid = 1'b0;
   logic        tx_ready, rx_valid, busy, sck, mosi, cs;
   logic [15:0] rx_data;
   logic        miso = 1'b0;

   hps_spi_master u_dut (
      .i_sys_clk (clk),      .i_reset   (rst),
      .i_tx_data (tx_data),  .i_tx_last (tx_last),  .i_tx_valid (tx_valid),
      .o_tx_ready(tx_ready), .o_rx_data (rx_data),  .o_rx_valid (rx_valid),
      .o_busy    (busy),     .o_spi_clk (sck),      .o_spi_mosi (mosi),
      .i_spi_miso(miso),     .o_spi_cs  (cs)
   );

   logic [15:0] d1_tx_data = '0;
   logic        d1_tx_last = 1'b0;
   logic        d1_tx_valid = 1'b0;
   logic        d1_tx_ready, d1_rx_valid, d1_busy, d1_sck, d1_mosi, d1_cs;
   logic [15:0] d1_rx_data;
   logic        d1_miso = 1'b0;

   hps_spi_master #(.CLK_DIV(1)) u_dut1 (
      .i_sys_clk (clk),         .i_reset   (rst),
      .i_tx_data (d1_tx_data),  .i_tx_last (d1_tx_last),  .i_tx_valid (d1_tx_valid),
      .o_tx_ready(d1_tx_ready), .o_rx_data (d1_rx_data),  .o_rx_valid (d1_rx_valid),
      .o_busy    (d1_busy),     .o_spi_clk (d1_sck),      .o_spi_mosi (d1_mosi),
      .i_spi_miso(d1_miso),     .o_spi_cs  (d1_cs)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave for the default instance plus link monitors, all sampled on the falling sys_clk edge.
   logic [15:0] replies [0:15];
   logic [15:0] slv_got [0:15];
   logic [15:0] rx_got  [0:15];
   logic [15:0] slv_sh = '0;
   logic        p_sck = 1'b0, p_mosi = 1'b0, p_cs = 1'b1, first_rise = 1'b0;
   int cyc = 0, slv_bit = 0, slv_word = 0, rx_cnt = 0, acc_cnt = 0, cs_rise_cnt = 0;
   int cs_low_run = 0, cs_low_len = 0, cs_high_run = 0, cs_high_len = 0;
   int viol_mosi = 0, viol_rdy = 0, viol_gap = 0, rdy_cs_low = 0, acc_cyc = 0, rise_dly = 0;

   always @(negedge clk) begin
      cyc    <= cyc + 1;
      p_sck  <= sck;
      p_mosi <= mosi;
      p_cs   <= cs;
      if (tx_valid && tx_ready) begin
         acc_cnt <= acc_cnt + 1;
         if (cs) begin
            acc_cyc    <= cyc;
            first_rise <= 1'b1;
         end
      end
      if (sck && !p_sck) begin
         miso <= replies[slv_word][15 - slv_bit];
         if (first_rise) begin
            rise_dly   <= cyc - acc_cyc;
            first_rise <= 1'b0;
         end
      end
      if (!sck && p_sck && !cs) begin
         if (slv_bit == 15) begin
            slv_got[slv_word] <= {slv_sh[14:0], p_mosi};
            slv_word <= slv_word + 1;
            slv_bit  <= 0;
         end else begin
            slv_sh  <= {slv_sh[14:0], p_mosi};
            slv_bit <= slv_bit + 1;
         end
      end else if (cs) begin
         slv_bit <= 0;
      end
      if (rx_valid) begin
         rx_got[rx_cnt] <= rx_data;
         rx_cnt <= rx_cnt + 1;
      end
      if (!cs) begin
         cs_low_run  <= cs_low_run + 1;
         cs_high_run <= 0;
         if (p_cs) cs_high_len <= cs_high_run;
      end else begin
         cs_high_run <= cs_high_run + 1;
         cs_low_run  <= 0;
         if (!p_cs) begin
            cs_low_len  <= cs_low_run;
            cs_rise_cnt <= cs_rise_cnt + 1;
         end
      end
      if ((mosi != p_mosi) && sck && !cs) viol_mosi <= viol_mosi + 1;
      if (tx_ready && sck) viol_rdy <= viol_rdy + 1;
      if (tx_ready && cs && busy) viol_gap <= viol_gap + 1;
      if (tx_ready && !cs) rdy_cs_low <= rdy_cs_low + 1;
   end

   logic [15:0] d1_reply = 16'h3C5A;
   logic [15:0] d1_sh = '0, d1_rx = '0;
   logic        d1_p_sck = 1'b0, d1_p_mosi = 1'b0;
   int d1_bit = 0, d1_lastrise = 0, d1_period = 0, d1_rx_cnt = 0;

   always @(negedge clk) begin
      d1_p_sck  <= d1_sck;
      d1_p_mosi <= d1_mosi;
      if (d1_sck && !d1_p_sck) begin
         d1_miso     <= d1_reply[15 - d1_bit];
         d1_lastrise <= cyc;
         d1_period   <= cyc - d1_lastrise;
      end
      if (!d1_sck && d1_p_sck && !d1_cs) begin
         d1_sh  <= {d1_sh[14:0], d1_p_mosi};
         d1_bit <= d1_bit + 1;
      end
      if (d1_rx_valid) begin
         d1_rx     <= d1_rx_data;
         d1_rx_cnt <= d1_rx_cnt + 1;
      end
   end

   task automatic send(input logic [15:0] d, input logic last);
      bit ok = 1'b0;
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (tx_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      tx_valid = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic wait_ready();
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(negedge clk);
         if (tx_ready) ok = 1'b1;
      end
      if (!ok) check("ready_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 5000 && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
      if (!ok) check("idle_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int  base_w, base_rx, base_acc, base_rise, base_rdy, stall_hi;
      bit  ok;
      for (int i = 0; i < 16; i++) replies[i] = 16'h0000;

      // Reset state and ready release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cs", cs, 1);
      check("rst_sck", sck, 0);
      check("rst_mosi", mosi, 0);
      check("rst_ready", tx_ready, 0);
      check("rst_rxv", rx_valid, 0);
      check("rst_rxd", rx_data, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("ready_before_edge", tx_ready, 0);
      @(negedge clk);
      check("ready_after_rst", tx_ready, 1);
      @(posedge clk); #1;

      // 1: single word.
      base_w = slv_word; base_rx = rx_cnt;
      replies[base_w] = 16'h1234;
      send(16'hA55A, 1'b1);
      wait_idle();
      check("t1_slave", slv_got[base_w], 16'hA55A);
      check("t1_rx", rx_got[base_rx], 16'h1234);
      check("t1_rxcnt", rx_cnt - base_rx, 1);
      check("t1_cs_low", cs_low_len, 138);
      check("t1_first_rise", rise_dly, 7);

      // 2: three-word transaction with a source stall before the second word.
      base_w = slv_word; base_rx = rx_cnt; base_rise = cs_rise_cnt;
      replies[base_w] = 16'hBEEF; replies[base_w+1] = 16'h0F0F; replies[base_w+2] = 16'h8001;
      send(16'h0001, 1'b0);
      wait_ready();
      stall_hi = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (sck || cs) stall_hi++;
      end
      @(posedge clk); #1;
      send(16'h8000, 1'b0);
      send(16'hFFFF, 1'b1);
      wait_idle();
      check("t2_slave0", slv_got[base_w], 16'h0001);
      check("t2_slave1", slv_got[base_w+1], 16'h8000);
      check("t2_slave2", slv_got[base_w+2], 16'hFFFF);
      check("t2_rx0", rx_got[base_rx], 16'hBEEF);
      check("t2_rx1", rx_got[base_rx+1], 16'h0F0F);
      check("t2_rx2", rx_got[base_rx+2], 16'h8001);
      check("t2_rxcnt", rx_cnt - base_rx, 3);
      check("t2_cs_rises", cs_rise_cnt - base_rise, 1);
      check("t2_stall_idle", stall_hi, 0);

      // 3: CLK_DIV=1 instance.
      d1_tx_data = 16'hC3C3; d1_tx_last = 1'b1; d1_tx_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (d1_tx_ready) ok = 1'b1;
      end
      @(posedge clk); #1 d1_tx_valid = 1'b0;
      if (!ok) check("t3_send_timeout", 0, 1);
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (!d1_busy) ok = 1'b1;
      end
      if (!ok) check("t3_idle_timeout", 0, 1);
      check("t3_slave", d1_sh, 16'hC3C3);
      check("t3_rx", d1_rx, 16'h3C5A);
      check("t3_rxcnt", d1_rx_cnt, 1);
      check("t3_period", d1_period, 2);
      @(posedge clk); #1;

      // 4: back-to-back transactions with tx_valid held.
      base_w = slv_word; base_rx = rx_cnt; base_rise = cs_rise_cnt;
      replies[base_w] = 16'hAAAA; replies[base_w+1] = 16'h5555;
      send(16'h1111, 1'b1);
      send(16'h2222, 1'b1);
      wait_idle();
      check("t4_slave0", slv_got[base_w], 16'h1111);
      check("t4_slave1", slv_got[base_w+1], 16'h2222);
      check("t4_rx0", rx_got[base_rx], 16'hAAAA);
      check("t4_rx1", rx_got[base_rx+1], 16'h5555);
      check("t4_gap_min", cs_high_len >= 4, 1);
      check("t4_cs_rises", cs_rise_cnt - base_rise, 2);

      // 5: asynchronous reset after the 7th SCK fall.
      base_w = slv_word; base_rx = rx_cnt;
      replies[base_w] = 16'hFFFF;
      send(16'h5A5A, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (slv_bit == 7 && sck) ok = 1'b1;
      end
      if (!ok) check("t5_bit7_timeout", 0, 1);
      #1 rst = 1'b1;
      #1;
      check("t5_cs_async", cs, 1);
      check("t5_sck_async", sck, 0);
      check("t5_ready_rst", tx_ready, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t5_no_rxv", rx_cnt - base_rx, 0);
      replies[base_w] = 16'hA5C3;
      @(posedge clk); #1;
      send(16'h00FF, 1'b1);
      wait_idle();
      check("t5_slave", slv_got[base_w], 16'h00FF);
      check("t5_rx", rx_got[base_rx], 16'hA5C3);

      // 6: tx_valid toggled while the transfer is in progress.
      base_w = slv_word; base_rx = rx_cnt; base_acc = acc_cnt; base_rdy = rdy_cs_low;
      replies[base_w] = 16'h9393;
      send(16'h6C6C, 1'b1);
      tx_data = 16'hDEAD; tx_last = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(posedge clk); #1;
         if (cs) ok = 1'b1;
         else tx_valid = ~tx_valid;
      end
      tx_valid = 1'b0;
      if (!ok) check("t6_cs_timeout", 0, 1);
      wait_idle();
      check("t6_accepts", acc_cnt - base_acc, 1);
      check("t6_slave", slv_got[base_w], 16'h6C6C);
      check("t6_rx", rx_got[base_rx], 16'h9393);
      check("t6_ready_cs_low", rdy_cs_low - base_rdy, 0);
      @(negedge clk);
      check("t6_ready_idle", tx_ready, 1);

      check("mosi_while_sck_high", viol_mosi, 0);
      check("ready_while_sck_high", viol_rdy, 0);
      check("ready_in_gap", viol_gap, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
